// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer step ticks, sequencer mode and $4017 bit layout.
// The length-counter stage imports this package as well.
package apu_pkg;

   localparam int APU_CNT_W = 16;
   localparam int APU_STEP1 = 7457;
   localparam int APU_STEP2 = 14913;
   localparam int APU_STEP3 = 22371;
   localparam int APU_STEP4 = 29829;
   localparam int APU_STEP5 = 37281;

   localparam int WR4017_MODE_BIT    = 7;
   localparam int WR4017_INHIBIT_BIT = 6;

   typedef enum logic {
      MODE_4STEP = 1'b0,
      MODE_5STEP = 1'b1
   } apu_mode_e;

   // A $4017 write lands the sequence reset 3 CPU ticks later on an even cycle, 4 on an odd one.
   function automatic logic [2:0] wrDelay(input logic parity);
      return parity ? 3'd4 : 3'd3;
   endfunction

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// CPU-side control strobes and frame-timing outputs of the APU frame sequencer.
interface apu_frame_sequencer_if;

   logic       cpu_tick;
   logic       wr_4017;
   logic [7:0] wr_data;
   logic       irq_ack;
   logic       quarter_frame;
   logic       half_frame;
   logic       frame_irq;
   logic       mode_5step;

   modport master (
      output cpu_tick, wr_4017, wr_data, irq_ack,
      input  quarter_frame, half_frame, frame_irq, mode_5step
   );

   modport slave (
      input  cpu_tick, wr_4017, wr_data, irq_ack,
      output quarter_frame, half_frame, frame_irq, mode_5step
   );

endinterface

// File: rtl/apu_frame_wr_delay.sv
// Pending sequence-reset timer armed by a $4017 write; fires o_seq_reset on the D-th later CPU tick.
module apu_frame_wr_delay
   import apu_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_cpu_tick,
   input  logic i_wr_4017,
   input  logic i_parity,
   output logic o_seq_reset
);

   logic [2:0] r_delay;

   // A new write always restarts the countdown; zero means nothing pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_delay <= 3'd0;
      end else if (i_wr_4017) begin
         r_delay <= wrDelay(i_parity);
      end else if (i_cpu_tick && (r_delay != 3'd0)) begin
         r_delay <= r_delay - 3'd1;
      end
   end

   assign o_seq_reset = i_cpu_tick && !i_wr_4017 && (r_delay == 3'd1);

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: quarter/half-frame enables and frame IRQ, programmed through $4017.
// Define APU_FRAME_IRQ_EN to build the frame IRQ; otherwise frame_irq is tied low.
module apu_frame_sequencer
   import apu_pkg::*;
#(
   parameter int CNT_W = APU_CNT_W,
   parameter int STEP1 = APU_STEP1,
   parameter int STEP2 = APU_STEP2,
   parameter int STEP3 = APU_STEP3,
   parameter int STEP4 = APU_STEP4,
   parameter int STEP5 = APU_STEP5
) (
   input logic                  clk,
   input logic                  reset,
   apu_frame_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] C_STEP1   = CNT_W'(STEP1);
   localparam logic [CNT_W-1:0] C_STEP2   = CNT_W'(STEP2);
   localparam logic [CNT_W-1:0] C_STEP3   = CNT_W'(STEP3);
   localparam logic [CNT_W-1:0] C_STEP4   = CNT_W'(STEP4);
   localparam logic [CNT_W-1:0] C_STEP4M1 = CNT_W'(STEP4 - 1);
   localparam logic [CNT_W-1:0] C_STEP5   = CNT_W'(STEP5);

   logic [CNT_W-1:0] r_cnt;
   logic             r_parity;
   apu_mode_e        r_mode;
   logic             r_quarter;
   logic             r_half;

   logic w_seqReset;
   logic w_atStep1, w_atStep2, w_atStep3, w_atStep4, w_atStep4m1, w_atStep5;
   logic w_quarter, w_half, w_wrap, w_irqSet;

   apu_frame_wr_delay u_wrDelay (
      .clk         (clk),
      .reset       (reset),
      .i_cpu_tick  (bus.cpu_tick),
      .i_wr_4017   (bus.wr_4017),
      .i_parity    (r_parity),
      .o_seq_reset (w_seqReset)
   );

   assign w_atStep1   = (r_cnt == C_STEP1);
   assign w_atStep2   = (r_cnt == C_STEP2);
   assign w_atStep3   = (r_cnt == C_STEP3);
   assign w_atStep4   = (r_cnt == C_STEP4);
   assign w_atStep4m1 = (r_cnt == C_STEP4M1);
   assign w_atStep5   = (r_cnt == C_STEP5);

   // Step events for the current count; in 5-step mode STEP4 is a silent tick.
   always_comb begin
      w_quarter = 1'b0;
      w_half    = 1'b0;
      w_wrap    = 1'b0;
      w_irqSet  = 1'b0;
      if (r_mode == MODE_5STEP) begin
         w_quarter = w_atStep1 | w_atStep2 | w_atStep3 | w_atStep5;
         w_half    = w_atStep2 | w_atStep5;
         w_wrap    = w_atStep5;
      end else begin
         w_quarter = w_atStep1 | w_atStep2 | w_atStep3 | w_atStep4;
         w_half    = w_atStep2 | w_atStep4;
         w_wrap    = w_atStep4;
         w_irqSet  = w_atStep4m1 | w_atStep4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_parity <= 1'b0;
      end else if (bus.cpu_tick) begin
         r_parity <= ~r_parity;
         if (w_seqReset || w_wrap) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode <= MODE_4STEP;
      end else if (bus.wr_4017) begin
         r_mode <= apu_mode_e'(bus.wr_data[WR4017_MODE_BIT]);
      end
   end

   // A write-triggered sequence reset replaces that tick's step event; 5-step mode clocks both units.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_quarter <= 1'b0;
         r_half    <= 1'b0;
      end else if (bus.cpu_tick && w_seqReset) begin
         r_quarter <= (r_mode == MODE_5STEP);
         r_half    <= (r_mode == MODE_5STEP);
      end else if (bus.cpu_tick) begin
         r_quarter <= w_quarter;
         r_half    <= w_half;
      end else begin
         r_quarter <= 1'b0;
         r_half    <= 1'b0;
      end
   end

   assign bus.quarter_frame = r_quarter;
   assign bus.half_frame    = r_half;
   assign bus.mode_5step    = (r_mode == MODE_5STEP);

`ifdef APU_FRAME_IRQ_EN
   logic       r_inhibit;
   logic       r_irq;
   logic [5:0] w_unusedWrBits;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inhibit <= 1'b0;
      end else if (bus.wr_4017) begin
         r_inhibit <= bus.wr_data[WR4017_INHIBIT_BIT];
      end
   end

   // Inhibit write clears unconditionally; otherwise a set event beats a same-cycle acknowledge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else if (bus.wr_4017 && bus.wr_data[WR4017_INHIBIT_BIT]) begin
         r_irq <= 1'b0;
      end else if (bus.cpu_tick && !w_seqReset && w_irqSet && !r_inhibit) begin
         r_irq <= 1'b1;
      end else if (bus.irq_ack) begin
         r_irq <= 1'b0;
      end
   end

   assign bus.frame_irq  = r_irq;
   assign w_unusedWrBits = bus.wr_data[5:0];
`else
   logic [8:0] w_unusedIrqPath;

   assign bus.frame_irq   = 1'b0;
   assign w_unusedIrqPath = {bus.irq_ack, bus.wr_data[6:0], w_irqSet};
`endif

endmodule
